// File: rtl/cpu_pkg.sv
// Shared decode constants and ALU helpers for the single-cycle RV32I-subset core.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    // Wrap-around arithmetic; slt compares as two's-complement.
    function automatic logic [31:0] alu_exec(alu_op_e op, logic [31:0] a, logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = signed'(a);
        sb = signed'(b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'd0, (sa < sb)};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x 32-bit register file: two combinational read ports, one synchronous write port.
// x0 reads as zero and is never written.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  rd,
    input  logic [31:0] wd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rd != 5'd0)) begin
            regs[rd] <= wd;
        end
    end

    assign rd1 = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rd2 = (rs2 == 5'd0) ? '0 : regs[rs2];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I-subset core (add/sub/and/or/slt/addi/lw/sw/beq) with internal
// instruction memory and an external combinational-read data memory.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    // Contents are loaded from outside; reset leaves them untouched.
    if (1) begin : imem
        logic [31:0] memory [0:IMEM_WORDS-1];
    end

    logic [29:0]      word_addr;
    logic [IDX_W-1:0] imem_idx;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;

    alu_op_e     alu_op;
    logic        reg_we;
    logic        use_imm;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic [31:0] ls_addr;
    logic        rf_we;
    logic [31:0] rf_wd;
    logic        branch_taken;
    logic [31:0] pc_next;

    assign word_addr = pc[31:2];
    assign imem_idx  = IDX_W'(word_addr % 30'(IMEM_WORDS));
    assign instr     = imem.memory[imem_idx];

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // Anything not explicitly recognised falls through as a NOP.
    always_comb begin
        alu_op  = ALU_ADD;
        reg_we  = 1'b0;
        use_imm = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        case (opcode)
            OP_R: begin
                reg_we = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
                    {F7_SUB,  F3_ADD}: alu_op = ALU_SUB;
                    {F7_BASE, F3_AND}: alu_op = ALU_AND;
                    {F7_BASE, F3_OR }: alu_op = ALU_OR;
                    {F7_BASE, F3_SLT}: alu_op = ALU_SLT;
                    default:           reg_we = 1'b0;
                endcase
            end
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    reg_we  = 1'b1;
                    use_imm = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_W) begin
                    reg_we = 1'b1;
                    is_lw  = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == F3_W) begin
                    is_sw = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    is_beq = 1'b1;
                end
            end
            default: ;
        endcase
    end

    regfile rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we),
        .rd    (instr[11:7]),
        .wd    (rf_wd),
        .rs1   (instr[19:15]),
        .rs2   (instr[24:20]),
        .rd1   (rs1_val),
        .rd2   (rs2_val)
    );

    assign alu_b   = use_imm ? imm_i : rs2_val;
    assign alu_res = alu_exec(alu_op, rs1_val, alu_b);
    assign ls_addr = rs1_val + (is_sw ? imm_s : imm_i);

    // Strobes are gated by rst_n so an instruction interrupted by reset has no effect.
    assign mem_read  = rst_n & is_lw;
    assign mem_write = rst_n & is_sw;
    assign mem_addr  = (is_lw || is_sw) ? ls_addr : '0;
    assign mem_wdata = is_sw ? rs2_val : '0;

    assign rf_we = rst_n & reg_we;
    assign rf_wd = is_lw ? mem_rdata : alu_res;

    assign branch_taken = is_beq && (rs1_val == rs2_val);
    assign pc_next      = branch_taken ? (pc + imm_b) : (pc + 32'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: runs a small program from a vector table and checks bus outputs,
// register and data-memory state, then exercises a mid-program reset.
module tb_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        tb_we = 1'b0;
    logic [5:0]  tb_addr = '0;
    logic [31:0] tb_data = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_core #(
        .IMEM_WORDS (256),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .instr     (instr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // External data memory: combinational read, write on rising edge.
    if (1) begin : dm
        logic [31:0] mem [0:63];
        always @(posedge clk) begin
            if (tb_we) begin
                mem[tb_addr] <= tb_data;
            end else if (mem_write) begin
                mem[mem_addr[7:2]] <= mem_wdata;
            end
        end
        assign mem_rdata = mem[mem_addr[7:2]];
    end

    // kind: 0 = no post-check, 1 = register idx == val, 2 = dm.mem[idx] == val
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          kind;
        int          idx;
        logic [31:0] val;
    } vec_t;

    vec_t tbl [16];
    vec_t sb [$];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_regs_zero(input string name);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            acc = acc | dut.rf.regs[i];
        end
        check(name, acc, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{32'h00002083, 32'd0,  1'b1, 1'b0, 32'd0,  32'd0,  1, 1,  32'd15};
        tbl[1]  = '{32'h00402103, 32'd4,  1'b1, 1'b0, 32'd4,  32'd0,  1, 2,  32'd7};
        tbl[2]  = '{32'h002081B3, 32'd8,  1'b0, 1'b0, 32'd0,  32'd0,  1, 3,  32'd22};
        tbl[3]  = '{32'h40208233, 32'd12, 1'b0, 1'b0, 32'd0,  32'd0,  1, 4,  32'd8};
        tbl[4]  = '{32'h0020F2B3, 32'd16, 1'b0, 1'b0, 32'd0,  32'd0,  1, 5,  32'd7};
        tbl[5]  = '{32'h0020E333, 32'd20, 1'b0, 1'b0, 32'd0,  32'd0,  1, 6,  32'd15};
        tbl[6]  = '{32'h0020A3B3, 32'd24, 1'b0, 1'b0, 32'd0,  32'd0,  1, 7,  32'd0};
        tbl[7]  = '{32'h00112433, 32'd28, 1'b0, 1'b0, 32'd0,  32'd0,  1, 8,  32'd1};
        tbl[8]  = '{32'h00302423, 32'd32, 1'b0, 1'b1, 32'd8,  32'd22, 2, 2,  32'd22};
        tbl[9]  = '{32'h00402623, 32'd36, 1'b0, 1'b1, 32'd12, 32'd8,  2, 3,  32'd8};
        tbl[10] = '{32'h00500013, 32'd40, 1'b0, 1'b0, 32'd0,  32'd0,  1, 0,  32'd0};
        tbl[11] = '{32'hFFF00493, 32'd44, 1'b0, 1'b0, 32'd0,  32'd0,  1, 9,  32'hFFFF_FFFF};
        tbl[12] = '{32'h00000000, 32'd48, 1'b0, 1'b0, 32'd0,  32'd0,  1, 11, 32'd0};
        tbl[13] = '{32'h0084A5B3, 32'd52, 1'b0, 1'b0, 32'd0,  32'd0,  1, 11, 32'd1};
        tbl[14] = '{32'h00B02823, 32'd56, 1'b0, 1'b1, 32'd16, 32'd1,  2, 4,  32'd1};
        tbl[15] = '{32'hFE108CE3, 32'd60, 1'b0, 1'b0, 32'd0,  32'd0,  0, 0,  32'd0};

        for (int i = 0; i < 256; i++) begin
            dut.imem.memory[i] = 32'h0000_0000;
        end
        for (int k = 0; k < 16; k++) begin
            dut.imem.memory[k] = tbl[k].instr;
            sb.push_back(tbl[k]);
        end

        // Preload data memory while the core is held in reset.
        tb_we = 1'b1; tb_addr = 6'd0; tb_data = 32'd15;
        @(posedge clk); #1;
        tb_addr = 6'd1; tb_data = 32'd7;
        @(posedge clk); #1;
        tb_we = 1'b0;
        @(negedge clk);

        check("reset pc", pc, 32'd0);
        check("reset mem_read", 32'(mem_read), 32'd0);
        check("reset mem_write", 32'(mem_write), 32'd0);
        check("reset rf.we", 32'(dut.rf.we), 32'd0);
        check_regs_zero("reset regs");

        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            v = sb.pop_front();
            check($sformatf("k%0d pc", k), pc, v.pc);
            check($sformatf("k%0d instr", k), instr, v.instr);
            check($sformatf("k%0d rd/wr", k), 32'({mem_read, mem_write}), 32'({v.rd, v.wr}));
            check($sformatf("k%0d mem_addr", k), mem_addr, v.addr);
            check($sformatf("k%0d mem_wdata", k), mem_wdata, v.wdata);
            @(posedge clk);
            @(negedge clk);
            case (v.kind)
                1: check($sformatf("k%0d x%0d", k, v.idx), dut.rf.regs[v.idx], v.val);
                2: check($sformatf("k%0d dm[%0d]", k, v.idx), dm.mem[v.idx], v.val);
                default: ;
            endcase
        end

        // beq x1,x1,-8 at pc 60 must land on 52; then arm a store and reset over it.
        check("beq target pc", pc, 32'd52);
        check("beq no strobe", 32'({mem_read, mem_write}), 32'd0);
        tb_we = 1'b1; tb_addr = 6'd4; tb_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        tb_we = 1'b0;
        @(negedge clk);
        check("loop x11", dut.rf.regs[11], 32'd1);
        check("dm[4] marker", dm.mem[4], 32'hDEAD_BEEF);
        check("pre-reset pc", pc, 32'd56);
        check("pre-reset mem_write", 32'(mem_write), 32'd1);
        check("pre-reset mem_addr", mem_addr, 32'd16);

        rst_n = 1'b0;
        #1;
        check("mid reset pc", pc, 32'd0);
        check("mid reset mem_write", 32'(mem_write), 32'd0);
        check("mid reset mem_read", 32'(mem_read), 32'd0);
        check("mid reset rf.we", 32'(dut.rf.we), 32'd0);
        check_regs_zero("mid reset regs");
        @(posedge clk);
        @(negedge clk);
        check("aborted store dm[4]", dm.mem[4], 32'hDEAD_BEEF);
        check("held reset pc", pc, 32'd0);

        rst_n = 1'b1;
        #1;
        check("restart pc", pc, 32'd0);
        check("restart mem_read", 32'(mem_read), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("restart x1", dut.rf.regs[1], 32'd15);
        check("restart pc+4", pc, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter IMEM_WORDS, default 256: instruction memory depth in 32-bit words.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 pc  output  32: address of the instruction currently executing.
REQ-006 instr  output  32: instruction word fetched at pc.
REQ-007 mem_read  output  1: high while the current instruction is lw.
REQ-008 mem_write  output  1: high while the current instruction is sw; the data memory writes on the next rising edge.
REQ-009 mem_addr  output  32: byte address rs1 + sign-extended offset, for lw/sw; 0 otherwise.
REQ-010 mem_wdata  output  32: rs2 value, for sw; 0 otherwise.
REQ-011 mem_rdata  input  32: combinational read data returned by the external data memory for mem_addr.

Function
REQ-012 The core shall be single-cycle RV32I subset: fetch, decode, execute, memory and writeback all complete within one clk period; CPI = 1.
REQ-013 Supported instructions:
- R-type: add, sub, and, or, slt (signed).
- I-type: addi, lw.
- S-type: sw.
- B-type: beq.
REQ-014 Any other encoding, including 32'h0000_0000, shall execute as a NOP: no register write, no memory strobe, pc += 4.
REQ-015 Instruction fetch shall be combinational from internal word array imem.memory, indexed by pc[31:2] modulo IMEM_WORDS.
REQ-016 pc shall advance by 4 each cycle; beq taken loads pc + sign-extended B-immediate.
REQ-017 Register file: 32 x 32-bit; two combinational read ports; one synchronous write port.
REQ-018 Register x0 shall read 0 always; writes to x0 shall be discarded.
REQ-019 Writeback data shall be mem_rdata for lw and the ALU result otherwise; we asserted only for R-type, addi and lw.
REQ-020 Arithmetic shall be 32-bit wrap-around with no overflow flag; slt writes 1 or 0 using a signed compare.
REQ-021 A register written in cycle N shall be visible to reads in cycle N+1; no forwarding is required.
REQ-022 mem_read and mem_write shall never both be high.

Reset
REQ-023 While rst_n = 0:
- pc = RESET_PC; all 31 writable registers = 0.
- mem_read = 0, mem_write = 0, register write enable = 0.
REQ-024 Reset assertion mid-instruction shall abort that instruction: no register or memory update.
REQ-025 imem.memory contents shall not be cleared by reset; they are preloaded by the bench.
REQ-026 The first instruction shall execute on the first rising edge after rst_n rises.

Structure
REQ-027 Package cpu_pkg shall hold opcode/funct3/funct7 constants and the ALU-operation enum.
REQ-028 The register file shall be sub-module regfile, instance name rf, exposing signals we, rd, wd and array regs[0:31] (hierarchically probed).
REQ-029 The instruction memory shall be instance/array imem.memory inside cpu_core.
REQ-030 Data memory shall be external, with combinational read and write-on-posedge; word index = addr[31:2].

Verification
REQ-031 Preload dm.mem[0]=15, dm.mem[1]=7; run lw x1,0(x0); lw x2,4(x0) -> x1=15, x2=7.
REQ-032 Run add/sub/and/or (32'h002081B3, 40208233, 0020F2B3, 0020E333) -> x3=22, x4=8, x5=7, x6=15.
REQ-033 Run slt x7,x1,x2 (0020A3B3) and slt x8,x2,x1 (00112433) -> x7=0, x8=1; repeat with negative operand -1 vs 1 -> 1.
REQ-034 Run sw x3,8(x0); sw x4,12(x0) -> dm.mem[2]=22, dm.mem[3]=8; mem_write pulses exactly one cycle each.
REQ-035 Write attempt to x0 (addi x0,x0,5) -> x0 stays 0; beq x1,x1,-8 -> pc decrements by 8.
REQ-036 Assert rst_n low mid-program -> pc=0 and regs=0 immediately, with no pending memory write.
